bit_deserializer: RTL and testbench
===================================

BIT_DESERIALIZER -- requirements
Module: bit_deserializer

Interface
REQ-001 Parameter WIDTH, default 8, meaning parallel word width in bits; legal range 2..32.
REQ-002 CK  input  1  clock; all state updates on the rising edge.
REQ-003 RN  input  1  reset; one clock domain, asynchronous, active-low.
REQ-004 sin_valid  input  1  serial bit present on sin_data this cycle.
REQ-005 sin_data  input  1  serial data bit, LSB of the word first.
REQ-006 sin_first  input  1  marks the accepted bit as bit 0 of a new word.
REQ-007 sin_ready  output  1  block accepts a bit this cycle.
REQ-008 out_valid  output  1  out_data holds a complete word.
REQ-009 out_data  output  WIDTH  assembled parallel word.
REQ-010 out_ready  input  1  downstream consumes the word this cycle.
REQ-011 frame_err  output  1  one-cycle pulse: partial word discarded by sin_first.

Function
REQ-012 A bit SHALL be accepted on a rising CK edge when sin_valid=1 and sin_ready=1; nothing else is sampled from the serial side.
REQ-013 The k-th accepted bit of a word (k=0..WIDTH-1) SHALL land in bit k of the assembled word.
REQ-014 A bit counter of $clog2(WIDTH) bits SHALL count accepted bits, wrap to 0 after bit WIDTH-1, and never exceed WIDTH-1.
REQ-015 Control FSM states SHALL be IDLE (count 0, no partial word), SHIFT (partial word), HOLD (full word in shift register, output register occupied).
REQ-016 IDLE->SHIFT on an accepted bit when WIDTH>1 bits remain; SHIFT->IDLE when the WIDTH-th bit is accepted and the output register is free; SHIFT->HOLD when the WIDTH-th bit is accepted and the output register is not free.
REQ-017 HOLD->IDLE on the edge where out_valid=1 and out_ready=1; the held word SHALL transfer to out_data on that same edge.
REQ-018 The output register is free if out_valid=0 or (out_valid=1 and out_ready=1) on that edge.
REQ-019 Latency: out_valid SHALL rise the cycle after the WIDTH-th bit is accepted when the output register is free.
REQ-020 sin_ready SHALL be 1 in IDLE and SHIFT and 0 in HOLD; decoded combinationally from state only.
REQ-021 out_valid SHALL stay 1 with out_data stable until out_ready=1; it drops on that edge unless a new word loads on the same edge.
REQ-022 Accepted bit with sin_first=1 SHALL be stored as bit 0 and counter set to 1; if counter was non-zero, the partial word SHALL be discarded and frame_err pulsed high for exactly the next cycle.
REQ-023 sin_first without an accepted bit SHALL be ignored.
REQ-024 sin_valid gaps SHALL not disturb the partial word or counter.
REQ-025 Simultaneous last bit and output drain SHALL load the new word with no stall cycle and no word loss.

Reset
REQ-026 While RN=0: out_valid=0, out_data=0, frame_err=0, counter=0, shift register=0, state IDLE, hence sin_ready=1.
REQ-027 Reset mid-word or in HOLD SHALL discard partial and held words with no output pulse after release.
REQ-028 The first rising CK edge after RN deasserts SHALL be able to accept a bit.

Structure
REQ-029 State typedef (IDLE/SHIFT/HOLD) and the WIDTH legality limits SHALL live in shared package deser_pkg.
REQ-030 The bit counter with wrap and load-to-1 behaviour SHALL be sub-module deser_bitcnt; all other logic stays in bit_deserializer.
REQ-031 All flops SHALL be reset by RN only; no latches; no combinational path from sin_valid to sin_ready.

Verification
REQ-032 WIDTH=8, out_ready=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles -> out_valid=1 one cycle after 8th bit, out_data=0xA5, frame_err=0.
REQ-033 out_ready=0, words 0x3C then 0xC3 back-to-back -> sin_ready=0 after 16th bit; raise out_ready -> 0x3C then 0xC3 delivered in order, sin_ready returns 1.
REQ-034 3 bits then sin_first with bit 1 followed by 7 bits of 0x00 -> frame_err high one cycle, out_data=0x01.
REQ-035 8th bit of 0x5A accepted on the edge 0xFF drains -> out_data=0x5A next cycle, out_valid stays 1, sin_ready never 0.
REQ-036 Random sin_valid gaps (50%) over 100 words -> output stream equals reference sequence.
REQ-037 RN pulsed low after 5 bits or in HOLD -> all outputs 0 immediately, sin_ready=1, next full word 0x81 delivered correctly.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared types and parameter limits for the serial-to-parallel bit deserializer.
package deser_pkg;

    localparam int unsigned DESER_WIDTH_MIN = 2;
    localparam int unsigned DESER_WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } deser_state_e;

    function automatic bit deser_width_legal(input int unsigned w);
        return (w >= DESER_WIDTH_MIN) && (w <= DESER_WIDTH_MAX);
    endfunction

endpackage

// File: rtl/deser_bitcnt.sv
// Accepted-bit counter: counts 0..WIDTH-1 and wraps; a word-start bit forces it to 1.
module deser_bitcnt
    import deser_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             inc,
    input  logic             load_one,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // load_one wins over inc: the start-of-word bit is itself bit 0, so the next index is 1
    always_comb begin
        cnt_d = cnt_q;
        if (load_one) begin
            cnt_d = CNT_W'(1);
        end else if (inc) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/bit_deserializer.sv
// LSB-first serial-to-parallel deserializer with a one-word output register and
// a HOLD state that back-pressures the serial side while both stages are full.
module bit_deserializer
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             sin_valid,
    input  logic             sin_data,
    input  logic             sin_first,
    output logic             sin_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             frame_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    if (!deser_width_legal(WIDTH)) begin : g_bad_width
        $error("bit_deserializer: WIDTH out of range");
    end

    deser_state_e     state_q;
    deser_state_e     state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic             frame_err_q;
    logic             frame_err_d;

    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             bit_inc;
    logic             bit_load;
    logic             word_done;
    logic             out_free;
    logic [WIDTH-1:0] word_c;

    // Ready depends on state only, never on sin_valid
    assign sin_ready = (state_q != ST_HOLD);
    assign accept    = sin_valid & sin_ready;
    assign bit_load  = accept & sin_first;
    assign bit_inc   = accept & ~sin_first;
    assign word_done = bit_inc & (cnt == CNT_W'(WIDTH - 1));
    assign out_free  = ~out_valid_q | out_ready;

    // Right shift: after WIDTH accepted bits the first one sits in bit 0
    assign word_c = {sin_data, shreg_q[WIDTH-1:1]};

    deser_bitcnt #(
        .WIDTH(WIDTH)
    ) u_bitcnt (
        .CK      (CK),
        .RN      (RN),
        .inc     (bit_inc),
        .load_one(bit_load),
        .cnt     (cnt)
    );

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q & ~out_ready;
        frame_err_d = bit_load & (cnt != '0);

        if (bit_load) begin
            shreg_d = {sin_data, {(WIDTH - 1){1'b0}}};
        end else if (bit_inc) begin
            shreg_d = word_c;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A completed word bypasses HOLD whenever the output register frees up this edge
                if (word_done) begin
                    if (out_free) begin
                        out_data_d  = word_c;
                        out_valid_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_valid_q & out_ready) begin
                    out_data_d  = shreg_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// Scoreboard bench for bit_deserializer: stimulus pushes expected words, a monitor pops on each handshake.
module tb_bit_deserializer;

    localparam int unsigned WIDTH = 8;

    logic             CK = 1'b0;
    logic             RN = 1'b0;
    logic             sin_valid = 1'b0;
    logic             sin_data = 1'b0;
    logic             sin_first = 1'b0;
    logic             sin_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b1;
    logic             frame_err;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] exp_q[$];
    int               last_wait = 0;
    int               total_wait = 0;
    bit               rnd_ready = 1'b0;

    bit_deserializer #(
        .WIDTH(WIDTH)
    ) dut (
        .CK       (CK),
        .RN       (RN),
        .sin_valid(sin_valid),
        .sin_data (sin_data),
        .sin_first(sin_first),
        .sin_ready(sin_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .frame_err(frame_err)
    );

    always #5 CK = ~CK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one bit and hold it until the block accepts it; returns at posedge+1 after acceptance
    task automatic send_bit(input logic b, input logic f);
        int waited;
        bit acc;
        waited    = 0;
        acc       = 1'b0;
        sin_valid = 1'b1;
        sin_data  = b;
        sin_first = f;
        while (!acc) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge CK);
            acc = sin_ready;
            @(posedge CK);
            #1;
            if (!acc) begin
                waited++;
                if (waited > 500) begin
                    checks++;
                    errors++;
                    $display("FAIL send_bit_timeout: got stalled %0d cycles expected acceptance", waited);
                    acc = 1'b1;
                end
            end
        end
        last_wait  = waited;
        total_wait += waited;
        sin_valid  = 1'b0;
        sin_first  = 1'b0;
    endtask

    task automatic gap_cycle();
        sin_valid = 1'b0;
        sin_data  = 1'($urandom_range(0, 1));
        sin_first = 1'($urandom_range(0, 1));
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        @(posedge CK);
        #1;
        sin_first = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input bit push, input bit gaps, input bit first0);
        if (push) exp_q.push_back(w);
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) gap_cycle();
            send_bit(w[i], first0 && (i == 0));
        end
    endtask

    task automatic drain();
        int n;
        n         = 0;
        out_ready = 1'b1;
        while (((exp_q.size() != 0) || (out_valid == 1'b1)) && (n < 200)) begin
            @(posedge CK);
            #1;
            n++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] v;
        int               w0;

        // Monitor: every handshake observed at the falling edge consumes one expected word
        fork
            forever begin
                @(negedge CK);
                if (RN && out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word: got 0x%0h expected none", out_data);
                    end else begin
                        v = exp_q.pop_front();
                        if (out_data !== v) begin
                            errors++;
                            $display("FAIL word_order: got 0x%0h expected 0x%0h", out_data, v);
                        end
                    end
                end
            end
        join_none

        // Reset values
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_sin_ready", 32'(sin_ready), 32'd1);
        repeat (2) @(posedge CK);
        #1;
        RN = 1'b1;

        // Basic word, consecutive bits
        send_word(8'hA5, 1'b1, 1'b0, 1'b0);
        check("a5_out_valid", 32'(out_valid), 32'd1);
        check("a5_out_data", 32'(out_data), 32'hA5);
        check("a5_frame_err", 32'(frame_err), 32'd0);
        @(posedge CK);
        #1;
        check("a5_valid_drop", 32'(out_valid), 32'd0);
        drain();

        // Back-pressure: two words fill output register and shift register
        out_ready = 1'b0;
        send_word(8'h3C, 1'b1, 1'b0, 1'b1);
        send_word(8'hC3, 1'b1, 1'b0, 1'b1);
        check("bp_sin_ready_low", 32'(sin_ready), 32'd0);
        check("bp_out_data_3c", 32'(out_data), 32'h3C);
        repeat (3) @(posedge CK);
        #1;
        check("bp_out_data_stable", 32'(out_data), 32'h3C);
        check("bp_out_valid_stable", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        repeat (2) @(posedge CK);
        #1;
        check("bp_sin_ready_back", 32'(sin_ready), 32'd1);
        check("bp_out_valid_done", 32'(out_valid), 32'd0);
        drain();

        // Restart mid-word: three bits, then a new word start
        exp_q.push_back(8'h01);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check("fe_no_err_at_start", 32'(frame_err), 32'd0);
        send_bit(1'b1, 1'b1);
        check("fe_pulse", 32'(frame_err), 32'd1);
        send_bit(1'b0, 1'b0);
        check("fe_one_cycle", 32'(frame_err), 32'd0);
        for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b0);
        check("fe_out_data", 32'(out_data), 32'h01);
        check("fe_out_valid", 32'(out_valid), 32'd1);
        drain();

        // sin_first during a sin_valid gap must be ignored
        v = 8'h96;
        exp_q.push_back(v);
        for (int i = 0; i < 4; i++) send_bit(v[i], 1'b0);
        sin_valid = 1'b0;
        sin_first = 1'b1;
        sin_data  = 1'b1;
        @(posedge CK);
        #1;
        sin_first = 1'b0;
        check("gap_first_no_err", 32'(frame_err), 32'd0);
        for (int i = 4; i < 8; i++) send_bit(v[i], 1'b0);
        check("gap_out_data", 32'(out_data), 32'h96);
        drain();

        // Last bit lands on the edge the previous word drains
        out_ready = 1'b0;
        send_word(8'hFF, 1'b1, 1'b0, 1'b1);
        v = 8'h5A;
        exp_q.push_back(v);
        w0 = total_wait;
        for (int i = 0; i < 7; i++) send_bit(v[i], 1'b0);
        out_ready = 1'b1;
        send_bit(v[7], 1'b0);
        check("sim_no_stall", 32'(total_wait - w0), 32'd0);
        check("sim_out_valid", 32'(out_valid), 32'd1);
        check("sim_out_data", 32'(out_data), 32'h5A);
        check("sim_sin_ready", 32'(sin_ready), 32'd1);
        drain();

        // Random gaps and random back-pressure over 100 words
        rnd_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            send_word(WIDTH'($urandom), 1'b1, 1'b1, 1'($urandom_range(0, 1)));
        end
        rnd_ready = 1'b0;
        drain();

        // Reset after five bits
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        #2;
        RN = 1'b0;
        #1;
        check("rst5_out_valid", 32'(out_valid), 32'd0);
        check("rst5_out_data", 32'(out_data), 32'd0);
        check("rst5_frame_err", 32'(frame_err), 32'd0);
        check("rst5_sin_ready", 32'(sin_ready), 32'd1);
        @(posedge CK);
        #1;
        RN = 1'b1;
        v = 8'h81;
        exp_q.push_back(v);
        send_bit(v[0], 1'b0);
        check("rst5_first_edge_accept", 32'(last_wait), 32'd0);
        for (int i = 1; i < 8; i++) send_bit(v[i], 1'b0);
        check("rst5_out_data_81", 32'(out_data), 32'h81);
        drain();

        // Reset while holding two words
        out_ready = 1'b0;
        send_word(8'h11, 1'b0, 1'b0, 1'b1);
        send_word(8'h22, 1'b0, 1'b0, 1'b1);
        check("rsth_in_hold", 32'(sin_ready), 32'd0);
        #2;
        RN = 1'b0;
        #1;
        check("rsth_out_valid", 32'(out_valid), 32'd0);
        check("rsth_out_data", 32'(out_data), 32'd0);
        check("rsth_sin_ready", 32'(sin_ready), 32'd1);
        @(posedge CK);
        #1;
        RN = 1'b1;
        out_ready = 1'b1;
        send_word(8'h81, 1'b1, 1'b0, 1'b0);
        check("rsth_out_data_81", 32'(out_data), 32'h81);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
